// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 4;

  // Width of the bit counter that walks 0..width-1.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell shared by every bit position of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum is odd parity; carry is the majority of the three inputs.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// {Cout, sum} = A + B + Cin, presented with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             Cout
);

  localparam int                 CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;
  // Low result bits collected so far; the MSB comes straight from the cell
  // on the final RUN cycle, so only WIDTH-1 bits need storing.
  logic [WIDTH-2:0]   work;
  logic               carry;
  logic [CNT_W-1:0]   cnt;

  logic               fa_s;
  logic               fa_c;

  full_adder u_fa (
    .a   (opa[0]),
    .b   (opb[0]),
    .cin (carry),
    .s   (fa_s),
    .cout(fa_c)
  );

  // Control FSM and serial datapath; busy/done/sum/Cout are all registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      Cout  <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      work  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            opa   <= A;
            opb   <= B;
            carry <= Cin;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          // start is deliberately ignored here: no queuing, no resampling.
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= fa_c;
          work  <= (WIDTH-1)'({fa_s, work} >> 1);
          if (cnt == LAST) begin
            sum   <= {fa_s, work};
            Cout  <= fa_c;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done <= 1'b0;
          if (start) begin
            // Back-to-back request: go straight to RUN without an IDLE cycle.
            opa   <= A;
            opb   <= B;
            carry <= Cin;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for the 4-bit serial adder.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic       busy;
  logic       done;
  logic [3:0] sum;
  logic       Cout;

  int total = 0;
  int bad   = 0;

  serial_adder #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .Cout (Cout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Wait for done with a cycle bound; returns edges waited and busy cycles seen.
  task automatic wait_done(output int n, output int bcnt);
    n = 0;
    bcnt = 0;
    while (!done && n < 20) begin
      if (busy) bcnt++;
      tick;
      n++;
    end
  endtask

  // One complete operation from IDLE with result and timing checks.
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [3:0] es, input logic ec, input string tag);
    int n, bcnt;
    A = a; B = b; Cin = c; start = 1'b1;
    tick;
    start = 1'b0;
    // Scramble inputs after acceptance; they must not matter.
    A = 4'($urandom); B = 4'($urandom); Cin = 1'($urandom);
    wait_done(n, bcnt);
    chk({tag, "_lat"},  n,    4);
    chk({tag, "_busy"}, bcnt, 4);
    chk({tag, "_sum"},  sum,  es);
    chk({tag, "_cout"}, Cout, ec);
    tick;
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int n, bcnt, dcnt;
    logic [4:0] exp;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", Cout, 0);

    // Scenario 1 and 2
    do_op(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, "zero");
    do_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, "wrap");
    do_op(4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, "mix");

    // Scenario 3: start pulsed during RUN is ignored
    A = 4'b1111; B = 4'b1111; Cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    A = 4'b0001; B = 4'b0001; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dcnt++;
        chk("ign_sum",  sum,  4'b1111);
        chk("ign_cout", Cout, 1);
      end
      tick;
    end
    chk("ign_pulses", dcnt, 1);
    chk("ign_busy",   busy, 0);

    // Scenario 4: back-to-back, start held through DONE
    A = 4'b1111; B = 4'b1111; Cin = 1'b1; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(n, bcnt);
    chk("b2b_lat1", n, 4);
    chk("b2b_sum1", sum, 4'b1111);
    A = 4'b0010; B = 4'b0010; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_hold", sum,  4'b1111);
    chk("b2b_holdc", Cout, 1);
    wait_done(n, bcnt);
    chk("b2b_lat2",  n,    4);
    chk("b2b_sum2",  sum,  4'b0100);
    chk("b2b_cout2", Cout, 0);
    tick;

    // Scenario 5: reset during RUN
    A = 4'b1010; B = 4'b0110; Cin = 1'b0; start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum",  sum,  0);
    chk("abort_cout", Cout, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dcnt++;
      tick;
    end
    chk("abort_nodone", dcnt, 0);
    do_op(4'b1010, 4'b0110, 1'b0, 4'b0000, 1'b1, "after_abort");

    // Scenario 6: exhaustive sweep with random idle gaps
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          exp = 5'(a) + 5'(b) + 5'(c);
          do_op(4'(a), 4'(b), 1'(c), exp[3:0], exp[4], "sweep");
          repeat ($urandom_range(0, 2)) tick;
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
